// File: rtl/game_pkg.sv
// Shared game status encoding and small sizing helpers.
// Imported by the controller, debouncer and renderer.
package game_pkg;

  localparam int STATUS_W = 2;

  localparam logic [STATUS_W-1:0] STATUS_LOAD      = 2'b00;
  localparam logic [STATUS_W-1:0] STATUS_ACTIVATE  = 2'b01;
  localparam logic [STATUS_W-1:0] STATUS_PAUSE     = 2'b10;
  localparam logic [STATUS_W-1:0] STATUS_TERMINATE = 2'b11;

  typedef enum logic [STATUS_W-1:0] {
    ST_LOAD      = STATUS_LOAD,
    ST_ACTIVATE  = STATUS_ACTIVATE,
    ST_PAUSE     = STATUS_PAUSE,
    ST_TERMINATE = STATUS_TERMINATE
  } state_t;

  // Bits needed for a counter that runs 0..n-1 (never below 1).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/game_ctrl_fsm_key_debounce.sv
// Key synchroniser and debouncer: 2-flop sync, stable counter,
// debounced level and a single-cycle press pulse on its rising edge.
module key_debounce
  import game_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic clr,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int CW = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive clocks the synced key disagrees with the level.
  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/game_ctrl_fsm.sv
// Game controller: status FSM, key debounce, pixel enable,
// score prescaler with saturation and high-score tracking.
module game_ctrl_fsm
  import game_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DEB_CYCLES = 500000,
  parameter int SCORE_DIV  = 1000000,
  parameter int SCORE_W    = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                key_start,
  input  logic                key_pause,
  input  logic                crash,
  output logic                pix_en,
  output logic [STATUS_W-1:0] status,
  output logic [SCORE_W-1:0]  score,
  output logic [SCORE_W-1:0]  hi_score,
  output logic                game_over
);

  localparam int DIV_W = cnt_w(CLK_DIV);
  localparam int PRE_W = cnt_w(SCORE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCORE_DIV - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic start_evt, pause_evt;
  logic start_lvl, pause_lvl;
  logic unused_lvl;

  state_t             state_q, state_d;
  logic               go_q, go_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] hi_q, hi_d;
  logic               inc;
  logic [SCORE_W-1:0] score_inc;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start (
    .clk     (clk),
    .clr     (clr),
    .key_raw (key_start),
    .level   (start_lvl),
    .press   (start_evt)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_pause (
    .clk     (clk),
    .clr     (clr),
    .key_raw (key_pause),
    .level   (pause_lvl),
    .press   (pause_evt)
  );

  assign unused_lvl = start_lvl ^ pause_lvl;

  // Free-running pixel divider, wraps at CLK_DIV-1.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (div_q == DIV_LAST) div_d = '0;
  end

  // Status transitions; crash outranks pause in ACTIVATE.
  always_comb begin
    state_d = state_q;
    go_d    = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (start_evt) state_d = ST_ACTIVATE;
      end
      ST_ACTIVATE: begin
        if (crash) begin
          state_d = ST_TERMINATE;
          go_d    = 1'b1;
        end else if (pause_evt) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_evt || start_evt) state_d = ST_ACTIVATE;
      end
      ST_TERMINATE: begin
        if (start_evt) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Score prescaler, saturating score and high-score capture.
  always_comb begin
    pre_d     = pre_q;
    score_d   = score_q;
    hi_d      = hi_q;
    inc       = (state_q == ST_ACTIVATE) && (pre_q == PRE_LAST);
    score_inc = (score_q == SCORE_MAX) ? score_q
                                       : score_q + SCORE_W'(1);
    unique case (state_q)
      ST_LOAD: begin
        if (start_evt) begin
          pre_d   = '0;
          score_d = '0;
        end
      end
      ST_ACTIVATE: begin
        pre_d = inc ? '0 : pre_q + PRE_W'(1);
        if (inc) score_d = score_inc;
        if (crash && (score_d > hi_q)) hi_d = score_d;
      end
      ST_TERMINATE: begin
        if (start_evt) begin
          pre_d   = '0;
          score_d = '0;
        end
      end
      default: begin
        pre_d = pre_q;
      end
    endcase
  end

  // Controller registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_LOAD;
      go_q    <= 1'b0;
      div_q   <= '0;
      pre_q   <= '0;
      score_q <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      div_q   <= div_d;
      pre_q   <= pre_d;
      score_q <= score_d;
      hi_q    <= hi_d;
    end
  end

  assign pix_en    = (div_q == DIV_LAST);
  assign status    = state_q;
  assign score     = score_q;
  assign hi_score  = hi_q;
  assign game_over = go_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Scoreboard bench for game_ctrl_fsm: stimulus queues timed
// expectations, monitors compare on the falling clock edge.
module tb_game_ctrl_fsm;

  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic          key_start;
  logic          key_pause;
  logic          crash;
  logic          pix_en;
  logic [1:0]    status;
  logic [SW-1:0] score;
  logic [SW-1:0] hi_score;
  logic          game_over;

  game_ctrl_fsm #(
    .CLK_DIV    (4),
    .DEB_CYCLES (4),
    .SCORE_DIV  (10),
    .SCORE_W    (SW)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .key_start (key_start),
    .key_pause (key_pause),
    .crash     (crash),
    .pix_en    (pix_en),
    .status    (status),
    .score     (score),
    .hi_score  (hi_score),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  localparam int K_PIX = 0;
  localparam int K_ST  = 1;
  localparam int K_SC  = 2;
  localparam int K_HI  = 3;
  localparam int K_GO  = 4;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  exp_t vq[$];
  int   st_q[$];
  int   go_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int act_of(input int kind);
    case (kind)
      K_PIX:   return int'(pix_en);
      K_ST:    return int'(status);
      K_SC:    return int'(score);
      K_HI:    return int'(hi_score);
      default: return int'(game_over);
    endcase
  endfunction

  task automatic chk_at(input int c, input int kind, input int val);
    exp_t e;
    e.cyc  = c;
    e.kind = kind;
    e.val  = val;
    vq.push_back(e);
  endtask

  task automatic go_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic press(input bit which);
    if (which) key_pause = 1'b1;
    else key_start = 1'b1;
    repeat (10) @(negedge clk);
    key_pause = 1'b0;
    key_start = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Timed value checks popped from the scoreboard queue.
  initial begin
    int a;
    forever begin
      @(negedge clk);
      for (int i = vq.size() - 1; i >= 0; i--) begin
        if (vq[i].cyc <= cyc) begin
          checks++;
          a = act_of(vq[i].kind);
          if (vq[i].cyc < cyc) begin
            errors++;
            $display("FAIL missed kind=%0d cyc=%0d", vq[i].kind, vq[i].cyc);
          end else if (a != vq[i].val) begin
            errors++;
            $display("FAIL value kind=%0d cyc=%0d got=%0d want=%0d",
                     vq[i].kind, cyc, a, vq[i].val);
          end
          vq.delete(i);
        end
      end
    end
  end

  // Every status change and game_over pulse must be expected.
  initial begin
    logic [1:0] prev;
    int         e;
    prev = 2'bxx;
    forever begin
      @(negedge clk);
      if (!$isunknown(status) && !$isunknown(prev) && status != prev) begin
        checks++;
        if (st_q.size() == 0) begin
          errors++;
          $display("FAIL status_change got=%0d want=none", status);
        end else begin
          e = st_q.pop_front();
          if (int'(status) != e) begin
            errors++;
            $display("FAIL status_change got=%0d want=%0d", status, e);
          end
        end
      end
      prev = status;
      if (game_over === 1'b1) begin
        checks++;
        if (go_q.size() == 0) begin
          errors++;
          $display("FAIL game_over got=pulse want=none");
        end else begin
          e = go_q.pop_front();
          if (int'(hi_score) != e) begin
            errors++;
            $display("FAIL go_hi got=%0d want=%0d", hi_score, e);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int r, c, e, e2, e3, l;
    clr       = 1'b1;
    key_start = 1'b0;
    key_pause = 1'b0;
    crash     = 1'b0;
    repeat (3) @(negedge clk);
    r = cyc + 1;
    for (int n = 0; n < 12; n++) begin
      chk_at(r + n, K_PIX, (n % 4 == 3) ? 1 : 0);
      chk_at(r + n, K_ST, 0);
    end
    chk_at(r, K_SC, 0);
    chk_at(r, K_HI, 0);
    chk_at(r, K_GO, 0);
    chk_at(r + 11, K_SC, 0);
    @(negedge clk);
    clr = 1'b0;
    go_to(r + 12);

    // Two-clock bounce must not register.
    chk_at(r + 20, K_ST, 0);
    chk_at(r + 24, K_ST, 0);
    key_start = 1'b1;
    repeat (2) @(negedge clk);
    key_start = 1'b0;
    go_to(r + 24);

    // Held start enters ACTIVATE once.
    c = cyc;
    e = c + 7;
    st_q.push_back(1);
    chk_at(e - 1, K_ST, 0);
    chk_at(e, K_ST, 1);
    chk_at(e, K_SC, 0);
    press(0);
    chk_at(e + 29, K_SC, 2);
    chk_at(e + 35, K_SC, 3);
    go_to(e + 30);

    // Pause freezes score and prescaler.
    st_q.push_back(2);
    chk_at(e + 36, K_ST, 1);
    chk_at(e + 37, K_ST, 2);
    chk_at(e + 37, K_SC, 3);
    chk_at(e + 60, K_SC, 3);
    chk_at(e + 87, K_SC, 3);
    chk_at(e + 93, K_ST, 2);
    press(1);
    go_to(e + 87);

    // Resume continues from prescaler value 7.
    st_q.push_back(1);
    chk_at(e + 94, K_ST, 1);
    chk_at(e + 96, K_SC, 3);
    chk_at(e + 97, K_SC, 4);
    chk_at(e + 100, K_PIX, ((e + 100 - r) % 4 == 3) ? 1 : 0);
    chk_at(e + 101, K_PIX, ((e + 101 - r) % 4 == 3) ? 1 : 0);
    chk_at(e + 206, K_SC, 14);
    chk_at(e + 207, K_SC, 15);
    chk_at(e + 240, K_SC, 15);
    press(1);
    go_to(e + 240);

    // Crash ends the game; hi_score captures 15.
    st_q.push_back(3);
    go_q.push_back(15);
    chk_at(e + 241, K_ST, 3);
    chk_at(e + 241, K_GO, 1);
    chk_at(e + 241, K_HI, 15);
    chk_at(e + 242, K_GO, 0);
    chk_at(e + 250, K_SC, 15);
    chk_at(e + 250, K_ST, 3);
    crash = 1'b1;
    @(negedge clk);
    crash = 1'b0;
    go_to(e + 245);

    // Start returns to LOAD.
    st_q.push_back(0);
    chk_at(cyc + 7, K_ST, 0);
    press(0);

    // Pause and crash are ignored in LOAD.
    l = cyc;
    chk_at(l + 25, K_ST, 0);
    chk_at(l + 25, K_HI, 15);
    press(1);
    crash = 1'b1;
    @(negedge clk);
    crash = 1'b0;
    go_to(l + 30);

    // Second game.
    c  = cyc;
    e2 = c + 7;
    st_q.push_back(1);
    chk_at(e2, K_ST, 1);
    chk_at(e2, K_SC, 0);
    press(0);
    st_q.push_back(2);
    chk_at(e2 + 20, K_ST, 2);
    chk_at(e2 + 20, K_SC, 2);
    chk_at(e2 + 40, K_ST, 2);
    chk_at(e2 + 40, K_SC, 2);
    press(1);
    crash = 1'b1;
    @(negedge clk);
    crash = 1'b0;
    go_to(e2 + 36);
    st_q.push_back(1);
    chk_at(e2 + 43, K_ST, 1);
    press(1);
    go_to(e2 + 66);

    // Crash with pause event and score increment together.
    st_q.push_back(3);
    go_q.push_back(15);
    chk_at(e2 + 72, K_SC, 4);
    chk_at(e2 + 73, K_ST, 3);
    chk_at(e2 + 73, K_SC, 5);
    chk_at(e2 + 73, K_GO, 1);
    chk_at(e2 + 74, K_HI, 15);
    chk_at(e2 + 80, K_SC, 5);
    fork
      press(1);
      begin
        repeat (6) @(negedge clk);
        crash = 1'b1;
        @(negedge clk);
        crash = 1'b0;
      end
    join

    // Third game aborted by clr.
    st_q.push_back(0);
    press(0);
    c  = cyc;
    e3 = c + 7;
    st_q.push_back(1);
    chk_at(e3, K_ST, 1);
    press(0);
    chk_at(e3 + 24, K_SC, 2);
    go_to(e3 + 25);
    st_q.push_back(0);
    chk_at(e3 + 26, K_ST, 0);
    chk_at(e3 + 26, K_SC, 0);
    chk_at(e3 + 26, K_HI, 0);
    chk_at(e3 + 26, K_GO, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (5) @(negedge clk);

    checks++;
    if (vq.size() != 0 || st_q.size() != 0 || go_q.size() != 0) begin
      errors++;
      $display("FAIL leftovers got=%0d/%0d/%0d want=0/0/0",
               vq.size(), st_q.size(), go_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
